// File: rtl/tl_sensor_cond_if.sv
// Four-lane detector bundle between the loop-detector inputs and the light controller.
// master drives raw detectors and observes presence; slave is the conditioning block.
interface tl_sensor_cond_if;
  logic det_a;
  logic det_al;
  logic det_b;
  logic det_bl;
  logic Ta;
  logic Tal;
  logic Tb;
  logic Tbl;

  modport master (
    output det_a, det_al, det_b, det_bl,
    input  Ta, Tal, Tb, Tbl
  );

  modport slave (
    input  det_a, det_al, det_b, det_bl,
    output Ta, Tal, Tb, Tbl
  );
endinterface

// File: rtl/tl_sensor_cond.sv
// Four independent detector lanes: sync, debounce, hold-over stretch, max-green gap insertion.
// Latency DEB+3 edges rising, DEB+3+HOLD falling; free-running, no backpressure.
module tl_sensor_lane #(
  parameter int DEB  = 4,
  parameter int HOLD = 8,
  parameter int MAXG = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic det,
  output logic t
);
  localparam int DW = $clog2(DEB) + 1;
  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int MW = $clog2(MAXG);

  logic          s1;
  logic          s;
  logic          f;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [MW-1:0] mcnt;
  logic          pres;

  // det is asynchronous to clk; s1 may go metastable, s is the first safe sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= det;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f    <= 1'b0;
      dcnt <= '0;
    end else if (s == f) begin
      dcnt <= '0;
    end else if (dcnt == DW'(DEB - 1)) begin
      f    <= s;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
    end else if (f) begin
      hcnt <= HW'(HOLD);
    end else if (hcnt != '0) begin
      hcnt <= hcnt - HW'(1);
    end
  end

  assign pres = f | (hcnt != '0);

  // mcnt tracks how long t has been high; the gap cycle forces the controller to see a 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t    <= 1'b0;
      mcnt <= '0;
    end else if (pres && t && (mcnt == MW'(MAXG - 1))) begin
      t    <= 1'b0;
      mcnt <= '0;
    end else if (pres) begin
      t    <= 1'b1;
      mcnt <= t ? (mcnt + MW'(1)) : '0;
    end else begin
      t    <= 1'b0;
      mcnt <= '0;
    end
  end
endmodule

module tl_sensor_cond #(
  parameter int DEB  = 4,
  parameter int HOLD = 8,
  parameter int MAXG = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  tl_sensor_cond_if.slave  bus
);
  logic [3:0] det;
  logic [3:0] t;

  assign det = {bus.det_bl, bus.det_b, bus.det_al, bus.det_a};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    tl_sensor_lane #(
      .DEB  (DEB),
      .HOLD (HOLD),
      .MAXG (MAXG)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .det     (det[g]),
      .t       (t[g])
    );
  end

  assign bus.Ta  = t[0];
  assign bus.Tal = t[1];
  assign bus.Tb  = t[2];
  assign bus.Tbl = t[3];
endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: default-parameter instance plus a DEB=1/HOLD=0/MAXG=2 corner instance,
// both fed the same detectors and compared every cycle against a behavioural lane model.
module tb_tl_sensor_cond;
  logic       clk;
  logic       reset_n;
  logic [3:0] det_vec;
  logic [7:0] dut_t;

  int checks;
  int errors;

  tl_sensor_cond_if m_if ();
  tl_sensor_cond_if c_if ();

  assign m_if.det_a  = det_vec[0];
  assign m_if.det_al = det_vec[1];
  assign m_if.det_b  = det_vec[2];
  assign m_if.det_bl = det_vec[3];
  assign c_if.det_a  = det_vec[0];
  assign c_if.det_al = det_vec[1];
  assign c_if.det_b  = det_vec[2];
  assign c_if.det_bl = det_vec[3];

  tl_sensor_cond #(.DEB(4), .HOLD(8), .MAXG(64)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (m_if)
  );

  tl_sensor_cond #(.DEB(1), .HOLD(0), .MAXG(2)) u_corner (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (c_if)
  );

  assign dut_t = {c_if.Tbl, c_if.Tb, c_if.Tal, c_if.Ta, m_if.Tbl, m_if.Tb, m_if.Tal, m_if.Ta};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Lane model in terms of observable history: s is det delayed two edges, f flips after DEB
  // equal opposing samples, presence lasts while f was 1 within the last HOLD+1 cycles,
  // and the output drops for one cycle after MAXG consecutive high cycles.
  typedef struct {
    bit s1;
    bit s;
    bit last;
    bit f;
    bit t;
    int srun;
    int age;
    int hrun;
  } lane_t;

  lane_t st[8];

  function automatic int deb_of(input int i);
    return (i < 4) ? 4 : 1;
  endfunction
  function automatic int hold_of(input int i);
    return (i < 4) ? 8 : 0;
  endfunction
  function automatic int maxg_of(input int i);
    return (i < 4) ? 64 : 2;
  endfunction

  function automatic lane_t reset_state(input int hold);
    lane_t n;
    n.s1 = 1'b0; n.s = 1'b0; n.last = 1'b0; n.f = 1'b0; n.t = 1'b0;
    n.srun = 0; n.hrun = 0;
    n.age = hold + 1;
    return n;
  endfunction

  function automatic lane_t step(input lane_t c, input bit det, input int deb, input int hold,
                                 input int maxg);
    lane_t n;
    bit    pres;
    n      = c;
    pres   = (c.age <= hold);
    n.t    = pres && !(c.t && (c.hrun == maxg));
    n.hrun = n.t ? (c.t ? c.hrun + 1 : 1) : 0;
    n.srun = (c.s == c.last) ? c.srun + 1 : 1;
    n.last = c.s;
    n.f    = ((c.s != c.f) && (n.srun >= deb)) ? c.s : c.f;
    n.age  = n.f ? 0 : ((c.age > hold) ? c.age : c.age + 1);
    n.s    = c.s1;
    n.s1   = det;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) st[i] <= reset_state(hold_of(i));
    end else begin
      for (int i = 0; i < 8; i++)
        st[i] <= step(st[i], det_vec[i[1:0]], deb_of(i), hold_of(i), maxg_of(i));
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++)
      check($sformatf("model_lane%0d", i), int'(dut_t[i]), int'(st[i].t));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rem[4];
    int cnt;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    det_vec = 4'h0;

    repeat (3) tick();
    check("por_Ta",  int'(m_if.Ta),  0);
    check("por_Tal", int'(m_if.Tal), 0);
    check("por_Tb",  int'(m_if.Tb),  0);
    check("por_Tbl", int'(m_if.Tbl), 0);
    reset_n = 1'b1;
    repeat (5) tick();

    // 3-cycle pulse is shorter than DEB and must vanish
    det_vec[2] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      check("glitch3_Tb", int'(m_if.Tb), 0);
      if (k == 3) det_vec[2] = 1'b0;
    end
    repeat (10) tick();

    // 4-cycle pulse: f high for 4 cycles, stretched by HOLD, so Tb high edges 7..18
    cnt = 0;
    det_vec[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check("pulse4_Tb", int'(m_if.Tb), int'(k >= 7 && k <= 18));
      if (m_if.Tb) cnt++;
      if (k == 4) det_vec[2] = 1'b0;
    end
    check("pulse4_len", cnt, 12);
    repeat (10) tick();

    det_vec[1] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      check("bridge_Tal", int'(m_if.Tal), int'(k >= 7));
      if (k == 20) det_vec[1] = 1'b0;
      if (k == 26) det_vec[1] = 1'b1;
    end
    det_vec[1] = 1'b0;
    repeat (40) tick();

    det_vec[3] = 1'b1;
    for (int k = 1; k <= 230; k++) begin
      tick();
      check("maxg_Tbl", int'(m_if.Tbl),
            int'(k >= 7 && k <= 214 && k != 71 && k != 136 && k != 201));
      check("corner_Tbl", int'(c_if.Tbl), int'(k >= 4 && k <= 203 && ((k - 4) % 3) != 2));
      if (k == 200) det_vec[3] = 1'b0;
    end
    repeat (10) tick();

    det_vec = 4'hF;
    repeat (30) tick();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_Ta",  int'(m_if.Ta),  0);
    check("arst_Tal", int'(m_if.Tal), 0);
    check("arst_Tb",  int'(m_if.Tb),  0);
    check("arst_Tbl", int'(m_if.Tbl), 0);
    check("arst_corner", int'(dut_t[7:4] != 4'h0), 0);
    @(negedge clk);
    repeat (2) tick();
    det_vec = 4'b0001;
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("rel_Ta", int'(m_if.Ta), int'(k >= 7));
      check("rel_Tb", int'(m_if.Tb), 0);
      check("rel_corner_Ta", int'(c_if.Ta), int'(k >= 4 && ((k - 4) % 3) != 2));
    end
    det_vec = 4'h0;
    repeat (20) tick();

    // mixed glitches, medium pulses and long runs per lane, with one reset mid-stream
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset_n = (c != 2000);
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          int r;
          det_vec[i] = ~det_vec[i];
          r = $urandom_range(0, 3);
          if (r == 0)      rem[i] = $urandom_range(1, 3);
          else if (r == 1) rem[i] = $urandom_range(4, 12);
          else             rem[i] = $urandom_range(10, 150);
        end else begin
          rem[i]--;
        end
      end
    end
    reset_n = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
